// File: rtl/fifo_rd_pkg.sv
// Shared defaults and sizing helpers for the FIFO read-side stream controller.
package fifo_rd_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int PKT_LEN_DEF   = 6;
    localparam int BUF_DEPTH_DEF = 4;
    localparam int PKT_CNT_W     = 16;

    // Index width for a range of 'depth' values; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int OCC_W_DEF = $clog2(BUF_DEPTH_DEF + 1);
    typedef logic [OCC_W_DEF-1:0] occ_t;

endpackage

// File: rtl/fifo_rd_buf.sv
// Circular skid buffer between the FIFO read port and the output stream.
module fifo_rd_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = BUF_DEPTH_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          head_data_o,
    output logic [occ_w(DEPTH)-1:0]    occ_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int OW = occ_w(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [OW-1:0]     occ_r;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // Storage array and write pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
        end else if (push_i) begin
            mem_r[wr_ptr_r] <= push_data_i;
            wr_ptr_r        <= next_ptr(wr_ptr_r);
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Read pointer and occupancy; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_r <= {PW{1'b0}};
            occ_r    <= {OW{1'b0}};
        end else begin
            if (pop_i) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_i, pop_i})
                2'b10:   occ_r <= occ_r + OW'(1);
                2'b01:   occ_r <= occ_r - OW'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign head_data_o = mem_r[rd_ptr_r];
    assign occ_o       = occ_r;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the dual-clock FIFO read port into a framed valid/ready stream.
// Define FIFO_RD_FWFT_EN when the attached FIFO is first-word-fall-through.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int PKT_LEN   = PKT_LEN_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [DATA_W-1:0]     fifo_dout_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    output logic [DATA_W-1:0]     m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic [PKT_CNT_W-1:0]  pkt_cnt_o
);

    localparam int OW = occ_w(BUF_DEPTH);
    localparam int BW = ptr_w(PKT_LEN);
    localparam logic [BW-1:0] BEAT_LAST = BW'(PKT_LEN - 1);

    logic [OW-1:0]        occ_s;
    logic [DATA_W-1:0]    head_s;
    logic                 rd_en_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 valid_s;
    logic                 last_s;
    logic [BW-1:0]        beat_r;
    logic [PKT_CNT_W-1:0] pkt_cnt_r;

`ifdef FIFO_RD_FWFT_EN
    // Fall-through data is captured on the same edge that acknowledges it.
    always_comb begin
        rd_en_s = 1'b0;
        if (!rst_i && enable_i && !fifo_empty_i && (int'(occ_s) < BUF_DEPTH)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    assign push_s = rd_en_s;
`else
    logic infl_r;

    // Reserve a buffer slot for every outstanding read so capture can never overflow.
    always_comb begin
        rd_en_s = 1'b0;
        if (!rst_i && enable_i && !fifo_empty_i
            && ((int'(occ_s) + int'(infl_r)) < BUF_DEPTH)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // One-cycle read latency: the word requested last cycle lands this edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            infl_r <= 1'b0;
        end else begin
            infl_r <= rd_en_s;
        end
    end

    assign push_s = infl_r;
`endif

    fifo_rd_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_s),
        .push_data_i (fifo_dout_i),
        .pop_i       (pop_s),
        .head_data_o (head_s),
        .occ_o       (occ_s)
    );

    assign valid_s = (occ_s != {OW{1'b0}});
    assign pop_s   = valid_s & m_ready_i;
    assign last_s  = valid_s & (beat_r == BEAT_LAST);

    // Beat position within the packet and completed-packet count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_r    <= {BW{1'b0}};
            pkt_cnt_r <= {PKT_CNT_W{1'b0}};
        end else if (pop_s) begin
            if (beat_r == BEAT_LAST) begin
                beat_r    <= {BW{1'b0}};
                pkt_cnt_r <= pkt_cnt_r + PKT_CNT_W'(1);
            end else begin
                beat_r    <= beat_r + BW'(1);
                pkt_cnt_r <= pkt_cnt_r;
            end
        end else begin
            beat_r    <= beat_r;
            pkt_cnt_r <= pkt_cnt_r;
        end
    end

    assign fifo_rd_en_o = rd_en_s;
    assign m_data_o     = head_s;
    assign m_valid_o    = valid_s;
    assign m_last_o     = last_s;
    assign pkt_cnt_o    = pkt_cnt_r;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream with a behavioural FIFO model (standard or FWFT).
module tb_fifo_rd_stream;

    localparam int DATA_W    = 8;
    localparam int BUF_DEPTH = 4;
    localparam int PKT_LEN   = 6;
`ifdef FIFO_RD_FWFT_EN
    localparam int FIRST_LAT = 1;
`else
    localparam int FIRST_LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [DATA_W-1:0] fifo_dout = 8'h00;
    logic              fifo_empty = 1'b1;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              m_last;
    logic [15:0]       pkt_cnt;

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH),
        .PKT_LEN   (PKT_LEN)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .fifo_dout_i  (fifo_dout),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (fifo_rd_en),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_last_o     (m_last),
        .pkt_cnt_o    (pkt_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rd_cnt  = 0;
    logic [7:0] wr_pend[$];
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int xfer_cyc[$];
    int exp_beat = 0;
    int exp_pkt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // FIFO model: words written by the bench appear on the next edge; reads pop in order.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (fifo_rd_en) begin
                rd_cnt = rd_cnt + 1;
`ifdef FIFO_RD_FWFT_EN
                if (fq.size() > 0) void'(fq.pop_front());
`else
                if (fq.size() > 0) fifo_dout <= fq.pop_front();
`endif
            end
            while (wr_pend.size() > 0) fq.push_back(wr_pend.pop_front());
            fifo_empty <= (fq.size() == 0);
`ifdef FIFO_RD_FWFT_EN
            fifo_dout <= (fq.size() > 0) ? fq[0] : 8'h00;
`endif
        end
    end

    // Monitor: checks each transferred beat against the scoreboard and stall stability.
    initial begin
        logic       stall;
        logic [7:0] hold_data;
        logic       hold_last;
        logic [7:0] e;
        stall = 1'b0;
        hold_data = 8'h00;
        hold_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall && m_valid) begin
                    chk("hold_data", 32'(m_data), 32'(hold_data));
                    chk("hold_last", 32'(m_last), 32'(hold_last));
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", 32'(m_data), 32'(e));
                        chk("beat_last", 32'(m_last), (exp_beat == PKT_LEN - 1) ? 32'd1 : 32'd0);
                        chk("beat_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt));
                        if (exp_beat == PKT_LEN - 1) exp_pkt = (exp_pkt + 1) % 65536;
                        exp_beat = (exp_beat + 1) % PKT_LEN;
                        xfer_cyc.push_back(cyc);
                    end
                    stall = 1'b0;
                end else if (m_valid) begin
                    stall     = 1'b1;
                    hold_data = m_data;
                    hold_last = m_last;
                end else begin
                    stall = 1'b0;
                end
            end
        end
    end

    task automatic write_byte(input logic [7:0] b);
        wr_pend.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic write_seq(input int base, input int n);
        for (int i = 0; i < n; i++) write_byte(8'(base + i));
    endtask

    // Reset drops any word already pulled from the FIFO but not yet delivered.
    task automatic do_reset();
        int lost;
        rst = 1'b1;
        lost = exp_q.size() - fq.size() - wr_pend.size();
        for (int i = 0; i < lost; i++) void'(exp_q.pop_front());
        exp_beat = 0;
        exp_pkt  = 0;
        #1;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int rd_base;
        enable = 1'b1;
        #1;
        do_reset();

        // Scenario 1: six bytes, constant ready, first-beat latency.
        m_ready = 1'b1;
        write_seq(0, 6);
        @(posedge clk);
        for (lat = 0; lat < 20; lat++) begin
            @(negedge clk);
            if (m_valid) break;
        end
        chk("first_latency", 32'(lat), 32'(FIRST_LAT));
        wait_drain(100);
        chk("s1_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // Scenario 2: back-pressure for 20 cycles limits reads to the buffer depth.
        @(posedge clk); #2;
        do_reset();
        m_ready = 1'b0;
        rd_base = rd_cnt;
        write_seq(0, 6);
        repeat (20) @(posedge clk);
        #1;
        chk("s2_reads_stalled", 32'(rd_cnt - rd_base), 32'(BUF_DEPTH));
        chk("s2_head_data", 32'(m_data), 32'h00);
        chk("s2_valid", 32'(m_valid), 32'd1);
        #1;
        m_ready = 1'b1;
        wait_drain(100);
        chk("s2_reads_total", 32'(rd_cnt - rd_base), 32'd6);

        // Scenario 3: twelve bytes stream back-to-back.
        do_reset();
        xfer_cyc.delete();
        write_seq(0, 12);
        wait_drain(100);
        chk("s3_beats", 32'(xfer_cyc.size()), 32'd12);
        if (xfer_cyc.size() == 12) chk("s3_no_gaps", 32'(xfer_cyc[11] - xfer_cyc[0]), 32'd11);
        chk("s3_pkt_cnt", 32'(pkt_cnt), 32'd2);

        // Scenario 4: enable dropped after the second read.
        do_reset();
        rd_base = rd_cnt;
        write_seq(0, 6);
        for (int c = 0; c < 20 && (rd_cnt - rd_base) < 2; c++) begin
            @(posedge clk);
            #1;
        end
        #1;
        enable = 1'b0;
        chk("s4_reads_at_drop", 32'(rd_cnt - rd_base), 32'd2);
        repeat (10) @(posedge clk);
        #2;
        chk("s4_reads_disabled", 32'(rd_cnt - rd_base), 32'd2);
        chk("s4_pending", 32'(exp_q.size()), 32'd4);
        enable = 1'b1;
        wait_drain(100);
        chk("s4_reads_total", 32'(rd_cnt - rd_base), 32'd6);

        // Scenario 5: asynchronous reset with three words buffered.
        do_reset();
        m_ready = 1'b0;
        write_seq(8'h10, 3);
        repeat (8) @(posedge clk);
        #2;
        enable = 1'b0;
        write_seq(8'h20, 3);
        repeat (2) @(posedge clk);
        #1;
        chk("s5_valid_before", 32'(m_valid), 32'd1);
        #2;
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        write_seq(8'h30, 3);
        wait_drain(100);
        chk("s5_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // Scenario 6: randomized traffic, ready and enable, with one reset mid-run.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #2;
            m_ready = ($urandom_range(3) != 0);
            enable  = ($urandom_range(7) != 0);
            if ($urandom_range(2) == 0) begin
                for (int k = 0; k <= int'($urandom_range(1)); k++) write_byte(8'($urandom));
            end
            if (i == 300) begin
                #1;
                do_reset();
            end
        end
        m_ready = 1'b1;
        enable  = 1'b1;
        wait_drain(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side controller for the team's dual-clock FIFO (fifo_top). It sits in the read clock domain, drains the FIFO through its rd_en/dout/empty interface, and presents the words as a valid/ready stream with packet framing. An internal buffer absorbs FIFO read latency, so downstream back-pressure never drops or duplicates a word.

Parameters:
DATA_W, 8, width of the FIFO data and the stream data.
BUF_DEPTH, 4, number of entries in the internal buffer; must be at least 2. A value of 3 or more sustains 1 word/cycle.
PKT_LEN, 6, stream beats per packet; m_last_o marks the final beat. Must be at least 1.

Ports:
clk_i  in  1  read-domain clock; same clock as the FIFO rd_clk_i
rst_i  in  1  reset, asynchronous, active-high
enable_i  in  1  when 1, the block may issue new FIFO reads
fifo_dout_i  in  DATA_W  FIFO read data
fifo_empty_i  in  1  FIFO empty flag
fifo_rd_en_o  out  1  FIFO read enable
m_data_o  out  DATA_W  stream data
m_valid_o  out  1  stream data valid
m_ready_i  in  1  downstream ready
m_last_o  out  1  final beat of a packet
pkt_cnt_o  out  16  count of completed packets; wraps at 2^16

Behaviour:
- Reset (asynchronous, active-high):
  - occupancy, in-flight flag, read/write pointers, beat counter and pkt_cnt_o all clear to 0; buffer contents clear to 0.
  - fifo_rd_en_o is forced 0 while rst_i = 1.
  - m_valid_o = 0, m_last_o = 0, m_data_o = 0.
- Reset mid-operation: a word in flight or buffered is discarded. After reset deasserts, reading resumes with the FIFO's next word.
- Read issue rule (standard-latency FIFO): fifo_rd_en_o = enable_i AND NOT fifo_empty_i AND (occ_q + infl_q < BUF_DEPTH).
  - The rule uses registered state only; there is no combinational path from m_ready_i.
- Read latency: a word requested with fifo_rd_en_o in cycle N is sampled on fifo_dout_i at the clock edge ending cycle N+1.
  - infl_q is set when rd_en issues and cleared when the word is captured.
  - A new rd_en in the capture cycle keeps infl_q = 1.
- Buffer: circular, BUF_DEPTH entries, write and read pointers of clog2(BUF_DEPTH) bits, wrapping at BUF_DEPTH.
- Output: m_valid_o = (occ_q != 0); m_data_o = head entry.
- Hold rule: while m_valid_o = 1 and m_ready_i = 0, m_data_o and m_last_o stay stable.
- Handshake: a beat transfers on a rising edge where m_valid_o = 1 and m_ready_i = 1.
- Simultaneous capture and transfer in one cycle: occupancy is unchanged and both pointers advance.
- Full buffer: occ_q + infl_q = BUF_DEPTH blocks reads, so overflow is impossible by construction.
- enable_i = 0: no new reads. A word already in flight is still captured, and buffered words still drain.
- Framing:
  - beat_q counts transfers from 0 to PKT_LEN-1 and wraps to 0.
  - m_last_o = m_valid_o AND (beat_q == PKT_LEN-1).
  - pkt_cnt_o increments on each transfer with m_last_o = 1.
  - With PKT_LEN = 1, every beat is last.
- FIFO empty toggling does not affect already-requested words.

Optional Feature:
Macro FIFO_RD_FWFT_EN.
- Defined: the FIFO is first-word-fall-through.
  - fifo_dout_i is valid whenever fifo_empty_i = 0, and fifo_rd_en_o acts as an acknowledge.
  - The word is captured at the same edge that fifo_rd_en_o is high.
  - infl_q is tied to 0, and the issue condition becomes occ_q < BUF_DEPTH.
- Undefined: standard one-cycle read latency, as described above.

Decomposition:
- Package fifo_rd_pkg holds:
  - default DATA_W and PKT_LEN;
  - PKT_CNT_W = 16;
  - a pointer-width helper (clog2);
  - a typedef for the occupancy count, sized clog2(BUF_DEPTH+1).
- Sub-module fifo_rd_buf: the circular buffer with push, pop, head data, occupancy and pointers.
- Top level keeps the issue logic, the in-flight tracking and the framing counters.

Test Plan:
- After reset, write 6 bytes 0x00..0x05 to the FIFO with m_ready_i = 1 and enable_i = 1.
  -> Beats 0x00..0x05 appear in order; m_last_o is high only on 0x05; pkt_cnt_o = 1.
- Same 6 bytes with m_ready_i = 0 for the first 20 cycles.
  -> fifo_rd_en_o pulses exactly BUF_DEPTH = 4 times, then stays 0.
  -> m_data_o holds 0x00 stably.
  -> After ready rises, all 6 bytes arrive in order with no duplicates.
- 12 bytes, constant ready, BUF_DEPTH = 4.
  -> After the first beat, 1 beat per cycle with no gaps.
  -> m_last_o on 0x05 and 0x0B; pkt_cnt_o = 2.
- Drop enable_i in the cycle of the second fifo_rd_en_o.
  -> The in-flight byte is still delivered; no further reads occur.
  -> After enable_i returns to 1, the remaining bytes follow in order.
- Assert rst_i asynchronously (mid-clock) while 3 words are buffered.
  -> m_valid_o and m_last_o drop immediately; pkt_cnt_o = 0.
  -> After release, the next FIFO word is delivered as beat 0.
- With FIFO_RD_FWFT_EN defined, repeat scenario 1.
  -> Identical output sequence, with the first beat one cycle earlier.
